// File: rtl/prbs_pkg.sv
// Shared types and tap constants for the PRBS burst sequencer.
// Holds the FSM state encoding and standard polynomial masks.
package prbs_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } state_t;

   localparam logic [6:0]  PRBS7  = 7'h60;
   localparam logic [14:0] PRBS15 = 15'h6000;
   localparam logic [30:0] PRBS31 = 31'h48000000;

endpackage

// File: rtl/prbs_burst_ctrl_if.sv
// Valid/ready bit stream from the sequencer to the serial datapath.
// master drives bits, slave accepts them.
interface prbs_burst_ctrl_if;

   logic bit_o;
   logic bit_valid;
   logic bit_ready;

   modport master (
      output bit_o,
      output bit_valid,
      input  bit_ready
   );

   modport slave (
      input  bit_o,
      input  bit_valid,
      output bit_ready
   );

endinterface

// File: rtl/prbs_lfsr.sv
// Fibonacci LFSR with load and step; a zero seed loads all-ones
// so the register can never lock up.
module prbs_lfsr
   import prbs_pkg::*;
#(
   parameter int               WIDTH = 7,
   parameter logic [WIDTH-1:0] TAPS  = PRBS7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   input  logic             step,
   output logic [WIDTH-1:0] q,
   output logic             msb
);

   assign msb = q[WIDTH-1];

   // shift register: load has priority over step
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '1;
      end else if (load) begin
         q <= (seed == '0) ? '1 : seed;
      end else if (step) begin
         q <= {q[WIDTH-2:0], ^(q & TAPS)};
      end
   end

endmodule

// File: rtl/prbs_burst_ctrl.sv
// Seeded, length-controlled PRBS burst sequencer over valid/ready.
// Define PRBS_BURST_CHECK_EN to add the loopback bit-error checker.
module prbs_burst_ctrl
   import prbs_pkg::*;
#(
   parameter int               WIDTH = 7,
   parameter logic [WIDTH-1:0] TAPS  = PRBS7,
   parameter int               LEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] seed_i,
   input  logic [LEN_W-1:0] len_i,
   prbs_burst_ctrl_if.master bus,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] remaining
`ifdef PRBS_BURST_CHECK_EN
   ,
   input  logic             rx_bit,
   input  logic             rx_valid,
   output logic [15:0]      err_cnt
`endif
);

   state_t           state;
   logic [WIDTH-1:0] seed_q;
   logic [LEN_W-1:0] len_q;
   logic             valid;
   logic             xfer;
   logic             ld;
   logic             accept;

   assign bus.bit_valid = valid;
   assign xfer   = valid & bus.bit_ready;
   assign ld     = (state == LOAD) & ~abort;
   assign accept = (state == IDLE) & start & ~abort;

   prbs_lfsr #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_tx (
      .clk   (clk),
      .reset (reset),
      .load  (ld),
      .seed  (seed_q),
      .step  (xfer),
      .q     (),
      .msb   (bus.bit_o)
   );

   // burst sequencing with registered valid/busy/done/remaining
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         seed_q    <= '0;
         len_q     <= '0;
         remaining <= '0;
         valid     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  seed_q <= seed_i;
                  len_q  <= len_i;
                  busy   <= 1'b1;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  remaining <= len_q;
                  if (len_q == '0) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     valid <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (xfer) begin
                  remaining <= remaining - LEN_W'(1);
               end
               if (abort) begin
                  valid <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (xfer && remaining == LEN_W'(1)) begin
                  valid <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef PRBS_BURST_CHECK_EN
   logic ref_msb;
   logic chk;

   assign chk = rx_valid & ((state == RUN) | (state == DONE));

   prbs_lfsr #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_ref (
      .clk   (clk),
      .reset (reset),
      .load  (ld),
      .seed  (seed_q),
      .step  (chk),
      .q     (),
      .msb   (ref_msb)
   );

   // saturating count of received bits that disagree with the reference
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt <= '0;
      end else if (accept) begin
         err_cnt <= '0;
      end else if (chk && (rx_bit != ref_msb) && (err_cnt != 16'hFFFF)) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Directed vector bench for prbs_burst_ctrl.
// Inputs driven and outputs sampled on the falling edge.
module tb_prbs_burst_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [6:0]  seed_i;
   logic [15:0] len_i;
   logic        busy;
   logic        done;
   logic [15:0] remaining;

   prbs_burst_ctrl_if bus ();

   logic flip;
`ifdef PRBS_BURST_CHECK_EN
   logic        rx_bit;
   logic        rx_valid;
   logic [15:0] err_cnt;
   assign rx_valid = bus.bit_valid & bus.bit_ready;
   assign rx_bit   = bus.bit_o ^ flip;
`endif

   prbs_burst_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .seed_i    (seed_i),
      .len_i     (len_i),
      .bus       (bus),
      .busy      (busy),
      .done      (done),
      .remaining (remaining)
`ifdef PRBS_BURST_CHECK_EN
      ,
      .rx_bit    (rx_bit),
      .rx_valid  (rx_valid),
      .err_cnt   (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // results of the last burst
   int           xf, done_seen, done_k, first_k, last_xk;
   int           end_k, abort_k, stall_err;
   logic         pav;
   logic [15:0]  rem2;
   logic [127:0] got;
   logic [6:0]   qs [128];

   task automatic burst(input logic [6:0] sd, input logic [15:0] ln,
                        input logic [3:0] pat, input int ab_at,
                        input int rs_at, input bit inv);
      int   k;
      logic prev_stall, prev_bit;
      xf = 0; done_seen = 0; done_k = -1; first_k = -1;
      last_xk = -1; end_k = -1; abort_k = -1; stall_err = 0;
      pav = 1'b1; rem2 = '1; got = '0;
      prev_stall = 1'b0; prev_bit = 1'b0;
      seed_i = sd; len_i = ln; start = 1'b1; abort = 1'b0;
      bus.bit_ready = pat[0]; flip = 1'b0;
      @(negedge clk);
      k = 1;
      while (k < 400) begin
         start = (k == rs_at);
         if (k == rs_at) begin
            seed_i = 7'h01;
            len_i  = 16'd3;
         end
         abort = 1'b0;
         flip  = 1'b0;
         bus.bit_ready = pat[k % 4];
         if (k == 2) rem2 = remaining;
         if (done) begin
            done_seen++;
            done_k = k;
         end
         if (abort_k >= 0 && k == abort_k + 1) pav = bus.bit_valid;
         if (prev_stall && (!bus.bit_valid || bus.bit_o !== prev_bit))
            stall_err++;
         if (bus.bit_valid && first_k < 0) first_k = k;
         if (bus.bit_valid && bus.bit_ready) begin
            got[xf] = bus.bit_o;
            qs[xf % 128] = dut.u_tx.q;
            flip = inv && (xf == 3);
            last_xk = k;
            xf++;
            if (xf == ab_at) begin
               abort = 1'b1;
               abort_k = k;
            end
         end
         prev_stall = bus.bit_valid & ~bus.bit_ready;
         prev_bit   = bus.bit_o;
         if (!busy) begin
            end_k = k;
            break;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      abort = 1'b0;
      if (end_k < 0) begin
         checks++;
         errors++;
         $display("FAIL burst_timeout: busy still %0b expected 0", busy);
      end
   endtask

   typedef struct {
      logic [6:0]  seed;
      logic [15:0] len;
      logic [3:0]  pat;
      logic [15:0] exp;
      int          first;
      int          dk;
   } vec_t;

   vec_t vecs [7];
   logic [127:0] ref_bits;
   logic [127:0] seen;
   int dup;

   initial begin
      vecs[0] = '{7'h7F, 16'd8,  4'hF, 16'h007F,  2, 10};
      vecs[1] = '{7'h00, 16'd8,  4'hF, 16'h007F,  2, 10};
      vecs[2] = '{7'h01, 16'd8,  4'hF, 16'h0040,  2, 10};
      vecs[3] = '{7'h40, 16'd4,  4'hF, 16'h0001,  2,  6};
      vecs[4] = '{7'h60, 16'd4,  4'hF, 16'h0003,  2,  6};
      vecs[5] = '{7'h01, 16'd10, 4'h9, 16'h0040,  2, 21};
      vecs[6] = '{7'h7F, 16'd0,  4'hF, 16'h0000, -1,  2};

      reset = 1'b1; start = 1'b0; abort = 1'b0; flip = 1'b0;
      seed_i = '0; len_i = '0; bus.bit_ready = 1'b0;
      #12;
      chk("reset_outputs",
          {bus.bit_valid, busy, done, bus.bit_o, remaining},
          {1'b0, 1'b0, 1'b0, 1'b1, 16'h0000});
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         burst(vecs[i].seed, vecs[i].len, vecs[i].pat, -1, -1, 1'b0);
         chk($sformatf("v%0d_bits", i), got, {112'h0, vecs[i].exp});
         chk($sformatf("v%0d_xfers", i), xf, vecs[i].len);
         chk($sformatf("v%0d_first", i), first_k, vecs[i].first);
         chk($sformatf("v%0d_done_cnt", i), done_seen, 1);
         chk($sformatf("v%0d_done_k", i), done_k, vecs[i].dk);
         chk($sformatf("v%0d_idle_k", i), end_k, vecs[i].dk + 1);
         chk($sformatf("v%0d_rem_load", i), rem2, vecs[i].len);
         chk($sformatf("v%0d_rem_end", i), remaining, 16'd0);
         chk($sformatf("v%0d_stall", i), stall_err, 0);
      end

      burst(7'h7F, 16'd127, 4'hF, -1, -1, 1'b0);
      ref_bits = got;
      chk("p7f_lfsr_wrap", dut.u_tx.q, 7'h7F);
      burst(7'h00, 16'd127, 4'hF, -1, -1, 1'b0);
      chk("p00_stream", got, ref_bits);
      chk("p00_xfers", xf, 127);
      chk("p00_lfsr_wrap", dut.u_tx.q, 7'h7F);
      seen = '0;
      dup = 0;
      for (int i = 0; i < 127; i++) begin
         if (seen[qs[i]]) dup++;
         seen[qs[i]] = 1'b1;
      end
      chk("p00_distinct", dup, 0);

      burst(7'h7F, 16'd20, 4'hF, 5, -1, 1'b0);
      chk("abort_xfers", xf, 5);
      chk("abort_bits", got, 128'h1F);
      chk("abort_no_done", done_seen, 0);
      chk("abort_valid_drop", pav, 1'b0);
      chk("abort_idle_k", end_k, abort_k + 1);
      chk("abort_remaining", remaining, 16'd15);
      burst(7'h7F, 16'd8, 4'hF, -1, -1, 1'b0);
      chk("after_abort_bits", got, 128'h7F);
      chk("after_abort_done", done_seen, 1);

      burst(7'h7F, 16'd8, 4'hF, -1, 4, 1'b0);
      chk("busy_start_bits", got, 128'h7F);
      chk("busy_start_xfers", xf, 8);
      @(negedge clk);
      chk("busy_start_idle", busy, 1'b0);

      seed_i = 7'h7F; len_i = 16'd50; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bus.bit_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("midrun_valid", bus.bit_valid, 1'b1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_outputs",
          {bus.bit_valid, busy, done, bus.bit_o, remaining},
          {1'b0, 1'b0, 1'b0, 1'b1, 16'h0000});
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

`ifdef PRBS_BURST_CHECK_EN
      burst(7'h7F, 16'd16, 4'hF, -1, -1, 1'b1);
      chk("chk_err_one", err_cnt, 16'd1);
      burst(7'h7F, 16'd16, 4'hF, -1, -1, 1'b0);
      chk("chk_err_zero", err_cnt, 16'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
